// File: rtl/image_cell_sequencer.sv
// Streams one frame of cells from the source memories through an external cell processor
// and writes the results to the result memory in address order.
module image_cell_sequencer #(
    parameter int unsigned CELL_DEPTH   = 8,
    parameter int unsigned OPCODE_W     = 4,
    parameter int unsigned USER_W       = 8,
    parameter int unsigned NUM_CELLS    = 64,
    parameter int unsigned PROC_LATENCY = 1,
    localparam int unsigned ADDR_W      = (NUM_CELLS > 2) ? $clog2(NUM_CELLS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [OPCODE_W-1:0]   opcode_in,
    input  logic [USER_W-1:0]     user_in,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [CELL_DEPTH-1:0] rd_dataA,
    input  logic [CELL_DEPTH-1:0] rd_dataB,
    output logic [CELL_DEPTH-1:0] cellA,
    output logic [CELL_DEPTH-1:0] cellB,
    output logic [USER_W-1:0]     userInputA,
    output logic [OPCODE_W-1:0]   opcode,
    input  logic [CELL_DEPTH-1:0] processedCell,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [CELL_DEPTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done
);

    // Stage 0 is visible the cycle after rd_en; the last stage is the write strobe itself.
    localparam int DEPTH = int'(PROC_LATENCY) + 3;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_CELLS - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [OPCODE_W-1:0]   opcode_q, opcode_d;
    logic [USER_W-1:0]     user_q, user_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [CELL_DEPTH-1:0] cell_a_q, cell_a_d;
    logic [CELL_DEPTH-1:0] cell_b_q, cell_b_d;
    logic [CELL_DEPTH-1:0] wr_data_q, wr_data_d;
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [ADDR_W-1:0]     addr_q [DEPTH];
    logic [ADDR_W-1:0]     addr_d [DEPTH];

    always_comb begin
        state_d   = state_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        opcode_d  = opcode_q;
        user_d    = user_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    opcode_d  = opcode_in;
                    user_d    = user_in;
                end
            end
            StRun: begin
                if (rd_addr_q == LastAddr) begin
                    rd_en_d = 1'b0;
                    state_d = StDrain;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (done_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_comb begin
        vld_d[0]  = rd_en_q;
        addr_d[0] = rd_addr_q;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
        cell_a_d  = vld_q[0] ? rd_dataA : cell_a_q;
        cell_b_d  = vld_q[0] ? rd_dataB : cell_b_q;
        // processedCell is valid PROC_LATENCY cycles after the cells were presented.
        wr_data_d = vld_q[DEPTH-2] ? processedCell : wr_data_q;
        done_d    = vld_q[DEPTH-2] && (addr_q[DEPTH-2] == LastAddr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            opcode_q  <= '0;
            user_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cell_a_q  <= '0;
            cell_b_q  <= '0;
            wr_data_q <= '0;
            vld_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            opcode_q  <= opcode_d;
            user_q    <= user_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cell_a_q  <= cell_a_d;
            cell_b_q  <= cell_b_d;
            wr_data_q <= wr_data_d;
            vld_q     <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign cellA      = cell_a_q;
    assign cellB      = cell_b_q;
    assign userInputA = user_q;
    assign opcode     = opcode_q;
    assign wr_en      = vld_q[DEPTH-1];
    assign wr_addr    = addr_q[DEPTH-1];
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_image_cell_sequencer.sv
// Directed bench: a 4-cell / latency-1 sequencer for job control, plus 8-cell sequencers at
// latency 0 and 8 for data and latency sweeps. Memories hold A[i]=i, B[i]=2i; processor adds.
module tb_image_cell_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0;
    logic       start1;
    logic [3:0] opcode_in;
    logic [7:0] user_in;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Instance 0: NUM_CELLS=4, PROC_LATENCY=1
    logic       rd_en0, wr_en0, busy0, done0;
    logic [1:0] rd_addr0, wr_addr0;
    logic [7:0] rd_a0, rd_b0, cell_a0, cell_b0, usr0, proc0, wr_data0;
    logic [3:0] opc0;

    image_cell_sequencer #(.NUM_CELLS(4), .PROC_LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .opcode_in(opcode_in), .user_in(user_in),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_dataA(rd_a0), .rd_dataB(rd_b0),
        .cellA(cell_a0), .cellB(cell_b0), .userInputA(usr0), .opcode(opc0),
        .processedCell(proc0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .busy(busy0), .done(done0)
    );

    always @(posedge clk) begin
        if (rd_en0) begin
            rd_a0 <= {6'd0, rd_addr0};
            rd_b0 <= {5'd0, rd_addr0, 1'b0};
        end
        proc0 <= cell_a0 + cell_b0;
    end

    // Instances 1 and 2: NUM_CELLS=8, PROC_LATENCY=0 and 8
    logic       rd_en1, wr_en1, busy1, done1, rd_en2, wr_en2, busy2, done2;
    logic [2:0] rd_addr1, wr_addr1, rd_addr2, wr_addr2;
    logic [7:0] rd_a1, rd_b1, cell_a1, cell_b1, usr1, proc1, wr_data1;
    logic [7:0] rd_a2, rd_b2, cell_a2, cell_b2, usr2, proc2, wr_data2;
    logic [3:0] opc1, opc2;
    logic [7:0] p2 [8];

    image_cell_sequencer #(.NUM_CELLS(8), .PROC_LATENCY(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .opcode_in(opcode_in), .user_in(user_in),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_dataA(rd_a1), .rd_dataB(rd_b1),
        .cellA(cell_a1), .cellB(cell_b1), .userInputA(usr1), .opcode(opc1),
        .processedCell(proc1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .busy(busy1), .done(done1)
    );

    image_cell_sequencer #(.NUM_CELLS(8), .PROC_LATENCY(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start1), .opcode_in(opcode_in), .user_in(user_in),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_dataA(rd_a2), .rd_dataB(rd_b2),
        .cellA(cell_a2), .cellB(cell_b2), .userInputA(usr2), .opcode(opc2),
        .processedCell(proc2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .busy(busy2), .done(done2)
    );

    assign proc1 = cell_a1 + cell_b1;
    assign proc2 = p2[7];

    always @(posedge clk) begin
        if (rd_en1) begin
            rd_a1 <= {5'd0, rd_addr1};
            rd_b1 <= {4'd0, rd_addr1, 1'b0};
        end
        if (rd_en2) begin
            rd_a2 <= {5'd0, rd_addr2};
            rd_b2 <= {4'd0, rd_addr2, 1'b0};
        end
        p2[0] <= cell_a2 + cell_b2;
        for (int i = 1; i < 8; i++) p2[i] <= p2[i-1];
    end

    initial begin
        int j;
        int n_wr;
        int n_done;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; opcode_in = '0; user_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_u0", 64'({rd_en0, rd_addr0, cell_a0, cell_b0, usr0, opc0, wr_en0,
                               wr_addr0, wr_data0, busy0, done0}), 64'd0);
        check("reset_u1", 64'({rd_en1, wr_en1, busy1, done1, opc1, usr1}), 64'd0);
        check("reset_u2", 64'({rd_en2, wr_en2, busy2, done2, wr_data2}), 64'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Job 1 (op 3, user 0x10), ignored start at cycle 2, back-to-back job 2 at cycle 9.
        @(posedge clk); #1; start0 = 1'b1; opcode_in = 4'd3; user_in = 8'h10;
        n_wr = 0;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk); #1;
            start0    = (k == 2) || (k == 9);
            opcode_in = (k == 2) ? 4'd7 : (k == 9) ? 4'd5 : 4'd0;
            user_in   = (k == 9) ? 8'h22 : 8'h00;
            @(negedge clk);
            j = (k <= 9) ? k : k - 9;
            check("busy", 64'(busy0), 64'(j >= 1 && j <= 8));
            check("rd_en", 64'(rd_en0), 64'(j <= 4));
            if (j <= 4) check("rd_addr", 64'(rd_addr0), 64'(j - 1));
            check("wr_en", 64'(wr_en0), 64'(j >= 5 && j <= 8));
            if (j >= 5 && j <= 8) begin
                check("wr_addr", 64'(wr_addr0), 64'(j - 5));
                check("wr_data", 64'(wr_data0), 64'(3 * (j - 5)));
            end
            check("done", 64'(done0), 64'(j == 8));
            check("opcode", 64'(opc0), (k <= 9) ? 64'd3 : 64'd5);
            check("user", 64'(usr0), (k <= 9) ? 64'h10 : 64'h22);
            if (j >= 3 && j <= 6) begin
                check("cellA", 64'(cell_a0), 64'(j - 3));
                check("cellB", 64'(cell_b0), 64'(2 * (j - 3)));
            end
            if (wr_en0) n_wr++;
        end
        check("write_count_2jobs", 64'(n_wr), 64'd8);

        // Reset two cycles into RUN, together with a start that must be discarded.
        @(posedge clk); #1; start0 = 1'b1; opcode_in = 4'd9; user_in = 8'h33;
        @(posedge clk); #1; start0 = 1'b0;
        @(posedge clk); #1; start0 = 1'b1; rst = 1'b1;
        @(posedge clk); #1; start0 = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("abort_zero", 64'({rd_en0, rd_addr0, cell_a0, cell_b0, usr0, opc0, wr_en0,
                                 wr_addr0, wr_data0, busy0, done0}), 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_quiet", 64'({rd_en0, wr_en0, done0, busy0}), 64'd0);
        end

        @(posedge clk); #1; start0 = 1'b1; opcode_in = 4'd6; user_in = 8'h44;
        n_wr = 0; n_done = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1; start0 = 1'b0;
            @(negedge clk);
            if (wr_en0) begin
                check("rerun_wr_addr", 64'(wr_addr0), 64'(n_wr));
                check("rerun_wr_data", 64'(wr_data0), 64'(3 * n_wr));
                n_wr++;
            end
            if (done0) n_done++;
        end
        check("rerun_writes", 64'(n_wr), 64'd4);
        check("rerun_done", 64'(n_done), 64'd1);
        check("rerun_opcode", 64'(opc0), 64'd6);
        check("rerun_idle", 64'(busy0), 64'd0);

        // Latency sweep: 8 cells at PROC_LATENCY 0 and 8.
        @(posedge clk); #1; start1 = 1'b1; opcode_in = 4'd2; user_in = 8'h55;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1; start1 = 1'b0;
            @(negedge clk);
            check("u1_rd_en", 64'(rd_en1), 64'(k <= 8));
            if (k <= 8) check("u1_rd_addr", 64'(rd_addr1), 64'(k - 1));
            check("u1_wr_en", 64'(wr_en1), 64'(k >= 4 && k <= 11));
            if (k >= 4 && k <= 11) begin
                check("u1_wr_addr", 64'(wr_addr1), 64'(k - 4));
                check("u1_wr_data", 64'(wr_data1), 64'(3 * (k - 4)));
            end
            check("u1_done", 64'(done1), 64'(k == 11));
            check("u2_rd_en", 64'(rd_en2), 64'(k <= 8));
            check("u2_wr_en", 64'(wr_en2), 64'(k >= 12 && k <= 19));
            if (k >= 12 && k <= 19) begin
                check("u2_wr_addr", 64'(wr_addr2), 64'(k - 12));
                check("u2_wr_data", 64'(wr_data2), 64'(3 * (k - 12)));
            end
            check("u2_done", 64'(done2), 64'(k == 19));
            check("u2_busy", 64'(busy2), 64'(k <= 19));
        end
        check("u2_user", 64'(usr2), 64'h55);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
